axi4lite_master: RTL and testbench

//   Initiator end of the 8-bit AXI4-Lite register bus. Accepts single read/write commands on a

---
 rtl/axi4lite_master.sv | 232 +++++++++++++++++++++++
 tb/tb_axi4lite_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master.sv
// ---------------------------------------------------------------------------
// axi4lite_master
//
// Initiator end of a narrow AXI4-Lite register bus. Each command taken on the
// cmd_* valid/ready port becomes exactly one AXI4-Lite read or write. The
// slave's response is returned on the rsp_* valid/ready port. Only one
// transaction is in flight at a time.
//
// Ports
//   m_axi_aclk, m_axi_aresetn : clock (rising edge) and synchronous
//                               active-low reset
//   cmd_valid/cmd_ready       : command handshake. cmd_ready is high only
//                               while idle and out of reset.
//   cmd_write/addr/wdata/wstrb: command payload. wdata/wstrb are unused for
//                               reads.
//   rsp_valid/rsp_ready       : response handshake
//   rsp_write/rdata/resp      : response payload. rdata is 0 for writes.
//   m_axi_aw*, m_axi_w*,
//   m_axi_b*, m_axi_ar*,
//   m_axi_r*                  : AXI4-Lite master channels
//
// Every output is a flop except cmd_ready, which decodes the state.
// ---------------------------------------------------------------------------
module axi4lite_master #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic              m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,  // AW and W outstanding
    WB   = 3'd2,  // waiting for B
    RA   = 3'd3,  // AR outstanding
    RD   = 3'd4,  // waiting for R
    RSP  = 3'd5   // presenting the response
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wstrb_q, wstrb_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;

  // State and output registers
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        // The AXI payload flops double as the command latch, so the
        // payload stays constant while the matching valid is high.
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RA;
          end
        end
      end

      WR: begin
        // AW and W retire independently. Once both valids have dropped,
        // the next cycle raises bready, so B is never accepted before
        // both address and data have been handed over.
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && m_axi_wready) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_q && !wvalid_q) begin
          bready_d = 1'b1;
          state_d  = WB;
        end
      end

      WB: begin
        if (bready_q && m_axi_bvalid) begin
          bready_d    = 1'b0;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end

      RA: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD;
        end
      end

      RD: begin
        if (rready_q && m_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Gated with reset so no command is taken while the block is held in reset
  assign cmd_ready     = (state_q == IDLE) && m_axi_aresetn;

  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_master.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_master
//
// Directed bench for axi4lite_master. A table of command records, each with
// its slave behaviour (ready/valid delays, response code) and the expected
// response, is played through a procedural slave. Hand-written sequences
// cover reset at start-up and reset in the middle of a write.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi4lite_master;

  localparam int BUDGET = 40;
  localparam int NV     = 8;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       cmd_valid, cmd_ready, cmd_write, cmd_wstrb;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_write;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [1:0] m_axi_awaddr, m_axi_araddr, m_axi_bresp, m_axi_rresp;
  logic       m_axi_awvalid, m_axi_awready, m_axi_wstrb, m_axi_wvalid, m_axi_wready;
  logic [7:0] m_axi_wdata, m_axi_rdata;
  logic       m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic       m_axi_rvalid, m_axi_rready;

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] mem [4];

  typedef struct {
    logic       write;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       strb;
    logic [1:0] resp;      // code the slave returns; also the expected rsp_resp
    int         aw_dly;    // cycles awready is held low after awvalid
    int         w_dly;     // cycles wready is held low after wvalid
    int         ar_dly;    // cycles arready is held low after arvalid
    int         slv_dly;   // cycles bvalid/rvalid lag bready/rready
    int         rsp_dly;   // cycles rsp_ready is held low
    logic       hold;      // keep cmd_valid high (next command) while busy
    logic       chk_lat;   // zero-wait case: check minimum latency
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4lite_master #(.ADDR_W(2), .DATA_W(8)) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(aresetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic aw_chan(input vec_t v);
    int n = 0;
    while (!m_axi_awvalid && n < BUDGET) begin @(negedge clk); n++; end
    check("awvalid_seen", m_axi_awvalid, 1);
    if (!m_axi_awvalid) return;
    check("awaddr", m_axi_awaddr, v.addr);
    for (int i = 0; i < v.aw_dly; i++) begin
      @(negedge clk);
      check("awvalid_hold", m_axi_awvalid, 1);
      check("awaddr_stable", m_axi_awaddr, v.addr);
      check("bready_early_aw", m_axi_bready, 0);
    end
    m_axi_awready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0;
    check("awvalid_drop", m_axi_awvalid, 0);
  endtask

  task automatic w_chan(input vec_t v);
    int n = 0;
    while (!m_axi_wvalid && n < BUDGET) begin @(negedge clk); n++; end
    check("wvalid_seen", m_axi_wvalid, 1);
    if (!m_axi_wvalid) return;
    check("wdata", {m_axi_wstrb, m_axi_wdata}, {v.strb, v.wdata});
    for (int i = 0; i < v.w_dly; i++) begin
      @(negedge clk);
      check("wvalid_hold", m_axi_wvalid, 1);
      check("wdata_stable", {m_axi_wstrb, m_axi_wdata}, {v.strb, v.wdata});
      check("bready_early_w", m_axi_bready, 0);
    end
    m_axi_wready = 1'b1;
    @(negedge clk);
    m_axi_wready = 1'b0;
    check("wvalid_drop", m_axi_wvalid, 0);
  endtask

  task automatic ar_chan(input vec_t v);
    int n = 0;
    while (!m_axi_arvalid && n < BUDGET) begin @(negedge clk); n++; end
    check("arvalid_seen", m_axi_arvalid, 1);
    if (!m_axi_arvalid) return;
    check("araddr", m_axi_araddr, v.addr);
    for (int i = 0; i < v.ar_dly; i++) begin
      @(negedge clk);
      check("arvalid_hold", m_axi_arvalid, 1);
      check("araddr_stable", m_axi_araddr, v.addr);
      check("rready_early", m_axi_rready, 0);
    end
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    check("arvalid_drop", m_axi_arvalid, 0);
    check("rready_after_ar", m_axi_rready, 1);
  endtask

  task automatic do_txn(input vec_t v, input vec_t nxt);
    int n = 0;
    int acc;
    logic [7:0] exp_rd;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_wstrb = v.strb;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < BUDGET) begin @(negedge clk); n++; end
    check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);               // accept edge has passed
    acc = cyc;
    if (v.hold) begin
      cmd_write = nxt.write;
      cmd_addr  = nxt.addr;
      cmd_wdata = nxt.wdata;
      cmd_wstrb = nxt.strb;
    end else begin
      cmd_valid = 1'b0;
    end
    check("cmd_ready_busy", cmd_ready, 0);

    if (v.write) begin
      check("valids_after_wr_accept", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b110);
      fork
        aw_chan(v);
        w_chan(v);
      join
      check("bready_before_both", m_axi_bready, 0);
      n = 0;
      while (!m_axi_bready && n < BUDGET) begin @(negedge clk); n++; end
      check("bready_seen", m_axi_bready, 1);
      check("arvalid_in_write", m_axi_arvalid, 0);
      for (int i = 0; i < v.slv_dly; i++) begin
        @(negedge clk);
        check("bready_hold", m_axi_bready, 1);
      end
      m_axi_bresp  = v.resp;
      m_axi_bvalid = 1'b1;
      if (v.strb) mem[v.addr] = v.wdata;
      @(negedge clk);
      m_axi_bvalid = 1'b0;
      m_axi_bresp  = 2'b00;
      check("bready_drop", m_axi_bready, 0);
    end else begin
      check("valids_after_rd_accept", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b001);
      ar_chan(v);
      for (int i = 0; i < v.slv_dly; i++) begin
        @(negedge clk);
        check("rready_hold", m_axi_rready, 1);
      end
      m_axi_rdata  = mem[v.addr];
      m_axi_rresp  = v.resp;
      m_axi_rvalid = 1'b1;
      @(negedge clk);
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = 8'h00;
      m_axi_rresp  = 2'b00;
      check("rready_drop", m_axi_rready, 0);
    end

    n = 0;
    while (!rsp_valid && n < BUDGET) begin @(negedge clk); n++; end
    check("rsp_valid", rsp_valid, 1);
    if (v.chk_lat) check("latency", cyc - acc, v.write ? 3 : 2);
    exp_rd = v.write ? 8'h00 : v.exp_rdata;
    check("rsp_write", rsp_write, v.write);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_resp", rsp_resp, v.resp);
    check("cmd_ready_in_rsp", cmd_ready, 0);
    for (int i = 0; i < v.rsp_dly; i++) begin
      @(negedge clk);
      check("rsp_valid_hold", rsp_valid, 1);
      check("rsp_payload_stable", {rsp_write, rsp_resp, rsp_rdata}, {v.write, v.resp, exp_rd});
      check("no_axi_valid_in_rsp", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
      check("cmd_ready_stall", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
    n_vec++;
    $display("txn %0d: %s addr=%0d wdata=0x%02h -> rsp_write=%0b rdata=0x%02h resp=%02b",
             n_vec, v.write ? "WR" : "RD", v.addr, v.wdata, rsp_write, rsp_rdata, rsp_resp);
  endtask

  initial begin
    vec_t post;
    //         wr    addr   wdata  strb  resp   aw w ar slv rsp hold  lat   exp_rdata
    vecs[0] = '{1'b1, 2'd2, 8'hA5, 1'b1, 2'b00, 0, 0, 0, 0, 0, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 2'd2, 8'hEE, 1'b0, 2'b00, 0, 0, 0, 0, 0, 1'b0, 1'b1, 8'hA5};
    vecs[2] = '{1'b1, 2'd1, 8'h3C, 1'b1, 2'b00, 3, 0, 0, 0, 0, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 2'd3, 8'h7E, 1'b0, 2'b11, 0, 2, 0, 2, 0, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 2'd3, 8'hEE, 1'b0, 2'b00, 0, 0, 2, 1, 0, 1'b0, 1'b0, 8'h44};
    vecs[5] = '{1'b0, 2'd1, 8'hEE, 1'b0, 2'b10, 0, 0, 0, 0, 5, 1'b0, 1'b0, 8'h3C};
    vecs[6] = '{1'b1, 2'd0, 8'hFF, 1'b1, 2'b00, 0, 0, 0, 0, 2, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'b00, 0, 0, 0, 0, 0, 1'b0, 1'b1, 8'hFF};
    post    = '{1'b0, 2'd3, 8'h00, 1'b0, 2'b00, 0, 0, 0, 0, 0, 1'b0, 1'b1, 8'h44};

    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    aresetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 2'd0; cmd_wdata = 8'h00; cmd_wstrb = 1'b0;
    rsp_ready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                         m_axi_rready, rsp_valid, rsp_write}, 0);
    check("reset_payload", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr,
                            rsp_rdata, rsp_resp}, 0);
    check("cmd_ready_in_reset", cmd_ready, 0);
    aresetn = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);
    n_vec++;

    for (int i = 0; i < NV; i++) begin
      int j;
      j = (i + 1 < NV) ? i + 1 : i;
      do_txn(vecs[i], vecs[j]);
    end

    // Reset in the middle of a write whose AW/W are never accepted
    cmd_write = 1'b1; cmd_addr = 2'd3; cmd_wdata = 8'h99; cmd_wstrb = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_awvalid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    repeat (2) @(negedge clk);
    check("mid_awvalid_hold", m_axi_awvalid, 1);
    aresetn = 1'b0;
    @(negedge clk);
    check("mid_reset_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                             m_axi_rready, rsp_valid}, 0);
    check("mid_reset_cmd_ready", cmd_ready, 0);
    aresetn = 1'b1;
    @(negedge clk);
    check("mid_release_cmd_ready", cmd_ready, 1);
    check("mid_release_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 0);
    n_vec++;
    $display("txn %0d: reset during WR -> cmd_ready=%0b awvalid=%0b", n_vec, cmd_ready, m_axi_awvalid);

    // Aborted write never reached the slave; address 3 still holds its old value
    do_txn(post, post);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
